// File: rtl/microcode_unit.sv
// Linear microcode fetch/issue unit: addresses a combinational micro-op store, registers
// the two-slot bundle and issues it, halting on a terminator. Optional MICROCODE_BUNDLE_COUNT_EN.
//
//   state   | meaning
//   ST_RUN  | fetching and issuing one bundle per cycle
//   ST_HALT | terminator seen; valids low, everything else frozen until reset
module microcode_unit #(
    parameter int UOP_BUF_SIZE           = 128,
    parameter int UOP_BUF_WIDTH          = 72,
    parameter int MAX_PREDICT_DEPTH_BITS = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [$clog2(UOP_BUF_SIZE)-1:0]   uop_addr,
    input  logic [UOP_BUF_WIDTH-1:0]          uop,
    output logic [31:0]                       slot0_instr,
    output logic [31:0]                       slot1_instr,
    output logic [MAX_PREDICT_DEPTH_BITS-1:0] slot0_tag,
    output logic [MAX_PREDICT_DEPTH_BITS-1:0] slot1_tag,
    output logic                              slot0_valid,
    output logic                              slot1_valid,
    output logic                              slot0_flag,
    output logic                              slot1_flag,
    output logic                              halted
`ifdef MICROCODE_BUNDLE_COUNT_EN
    ,
    output logic [31:0]                       bundle_count
`endif
);

    localparam int ADDR_W = $clog2(UOP_BUF_SIZE);
    localparam int SLOT_W = 36;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SLOT_W-1:0] slot0_raw, slot1_raw;
    logic              term0, term1;
    logic              load_fields;
    logic              valid0_nxt, valid1_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    assign slot0_raw = uop[2*SLOT_W-1 -: SLOT_W];
    assign slot1_raw = uop[SLOT_W-1:0];
    assign term0     = (slot0_raw[35:4] == 32'd0);
    assign term1     = (slot1_raw[35:4] == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            uop_addr    <= '0;
            slot0_instr <= '0;
            slot1_instr <= '0;
            slot0_tag   <= '0;
            slot1_tag   <= '0;
            slot0_valid <= 1'b0;
            slot1_valid <= 1'b0;
            slot0_flag  <= 1'b0;
            slot1_flag  <= 1'b0;
        end else begin
            state       <= state_nxt;
            uop_addr    <= addr_nxt;
            slot0_valid <= valid0_nxt;
            slot1_valid <= valid1_nxt;
            if (load_fields) begin
                slot0_instr <= slot0_raw[35:4];
                slot1_instr <= slot1_raw[35:4];
                slot0_tag   <= slot0_raw[2 +: MAX_PREDICT_DEPTH_BITS];
                slot1_tag   <= slot1_raw[2 +: MAX_PREDICT_DEPTH_BITS];
                slot0_flag  <= slot0_raw[0];
                slot1_flag  <= slot1_raw[0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_RUN && (term0 || term1)) begin
            state_nxt = ST_HALT;
        end
    end

    // A slot-0 terminator kills the whole bundle; a slot-1 terminator only kills slot 1.
    always_comb begin
        load_fields = 1'b0;
        valid0_nxt  = 1'b0;
        valid1_nxt  = 1'b0;
        addr_nxt    = uop_addr;
        if (state == ST_RUN) begin
            load_fields = 1'b1;
            valid0_nxt  = slot0_raw[1] & ~term0;
            valid1_nxt  = slot1_raw[1] & ~term0 & ~term1;
            if (!term0 && !term1) begin
                addr_nxt = uop_addr + 1'b1;
            end
        end
    end

    assign halted = (state == ST_HALT);

`ifdef MICROCODE_BUNDLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_count <= '0;
        end else if ((valid0_nxt || valid1_nxt) && (bundle_count != '1)) begin
            bundle_count <= bundle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_microcode_unit.sv
// Bench for microcode_unit: hand-derived vector table, corner sequences and a
// randomized run against a slot-rule reference model of the micro-op sequencer.
module tb_microcode_unit;

    localparam int SIZE = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  uop_addr;
    logic [71:0] uop;
    logic [31:0] slot0_instr, slot1_instr;
    logic [1:0]  slot0_tag, slot1_tag;
    logic        slot0_valid, slot1_valid, slot0_flag, slot1_flag, halted;
`ifdef MICROCODE_BUNDLE_COUNT_EN
    logic [31:0] bundle_count;
`endif

    logic [71:0] mem [SIZE];
    assign uop = mem[uop_addr];

    always #5 clk = ~clk;

    microcode_unit dut (
        .clk(clk),
        .reset(reset),
        .uop_addr(uop_addr),
        .uop(uop),
        .slot0_instr(slot0_instr),
        .slot1_instr(slot1_instr),
        .slot0_tag(slot0_tag),
        .slot1_tag(slot1_tag),
        .slot0_valid(slot0_valid),
        .slot1_valid(slot1_valid),
        .slot0_flag(slot0_flag),
        .slot1_flag(slot1_flag),
        .halted(halted)
`ifdef MICROCODE_BUNDLE_COUNT_EN
        ,
        .bundle_count(bundle_count)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model state
    int          m_addr = 0;
    logic        m_halted = 1'b0;
    logic [31:0] m_i0 = '0, m_i1 = '0;
    logic [1:0]  m_t0 = '0, m_t1 = '0;
    logic        m_v0 = 1'b0, m_v1 = 1'b0, m_f0 = 1'b0, m_f1 = 1'b0;
    logic [31:0] m_cnt = '0;

    typedef struct {
        logic [71:0] bundle;
        logic [6:0]  addr;
        logic        v0;
        logic        v1;
        logic        h;
        logic [31:0] i0;
        logic [31:0] i1;
    } vec_t;

    vec_t tbl[3];

    function automatic logic [35:0] mk_slot(logic [31:0] w, logic [1:0] t, logic v, logic f);
        return {w, t, v, f};
    endfunction

    function automatic logic [35:0] rand_slot(bit allow_term);
        logic [31:0] w;
        w = $urandom;
        if (allow_term && $urandom_range(0, 24) == 0) w = 32'd0;
        else if (w == 32'd0) w = 32'd1;
        return {w, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1))};
    endfunction

    task automatic cmp(input string nm, input logic [79:0] act, input logic [79:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic rst);
        logic [35:0] s0, s1;
        if (rst) begin
            m_addr = 0; m_halted = 1'b0; m_cnt = '0;
            m_i0 = '0; m_i1 = '0; m_t0 = '0; m_t1 = '0;
            m_v0 = 1'b0; m_v1 = 1'b0; m_f0 = 1'b0; m_f1 = 1'b0;
        end else if (m_halted) begin
            m_v0 = 1'b0;
            m_v1 = 1'b0;
        end else begin
            s0 = mem[m_addr][71:36];
            s1 = mem[m_addr][35:0];
            {m_i0, m_t0, m_v0, m_f0} = s0;
            {m_i1, m_t1, m_v1, m_f1} = s1;
            if (m_i0 == 32'd0) begin
                m_v0 = 1'b0; m_v1 = 1'b0; m_halted = 1'b1;
            end else if (m_i1 == 32'd0) begin
                m_v1 = 1'b0; m_halted = 1'b1;
            end else begin
                m_addr = (m_addr + 1) % SIZE;
            end
            if ((m_v0 || m_v1) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_model(input string nm);
        cmp(nm, {uop_addr, halted, slot0_instr, slot0_tag, slot0_valid, slot0_flag,
                 slot1_instr, slot1_tag, slot1_valid, slot1_flag},
                {7'(m_addr), m_halted, m_i0, m_t0, m_v0, m_f0, m_i1, m_t1, m_v1, m_f1});
`ifdef MICROCODE_BUNDLE_COUNT_EN
        cmp({nm, "_count"}, 80'(bundle_count), 80'(m_cnt));
`endif
    endtask

    task automatic cycle(input logic rst, input string nm);
        reset = rst;
        model_step(rst);
        @(posedge clk);
        #1;
        check_model(nm);
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = {rand_slot(0), rand_slot(0)};

        tbl[0] = '{ {mk_slot(32'h01205021, 2'd2, 1'b1, 1'b1), mk_slot(32'h01205021, 2'd2, 1'b1, 1'b1)},
                    7'd1, 1'b1, 1'b1, 1'b0, 32'h01205021, 32'h01205021 };
        tbl[1] = '{ {mk_slot(32'h25270004, 2'd2, 1'b1, 1'b0), mk_slot(32'h25270005, 2'd2, 1'b1, 1'b0)},
                    7'd2, 1'b1, 1'b1, 1'b0, 32'h25270004, 32'h25270005 };
        tbl[2] = '{ {mk_slot(32'h25270004, 2'd2, 1'b1, 1'b0), mk_slot(32'h0, 2'd2, 1'b1, 1'b0)},
                    7'd2, 1'b1, 1'b0, 1'b1, 32'h25270004, 32'h0 };
        for (int i = 0; i < 3; i++) mem[i] = tbl[i].bundle;

        repeat (3) cycle(1'b1, "reset");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, "table_model");
            cmp($sformatf("table_%0d", i),
                80'({uop_addr, slot0_valid, slot1_valid, halted, slot0_instr, slot1_instr}),
                80'({tbl[i].addr, tbl[i].v0, tbl[i].v1, tbl[i].h, tbl[i].i0, tbl[i].i1}));
        end
`ifdef MICROCODE_BUNDLE_COUNT_EN
        cmp("count_after_3", 80'(bundle_count), 80'd3);
`endif
        repeat (4) begin
            cycle(1'b0, "halt_hold");
            cmp("halt_hold_const",
                80'({uop_addr, slot0_valid, slot1_valid, halted, slot0_instr, slot1_instr}),
                80'({7'd2, 1'b0, 1'b0, 1'b1, 32'h25270004, 32'h0}));
        end

        cycle(1'b1, "reset_in_halt");
        cmp("reset_in_halt_zero",
            80'({uop_addr, halted, slot0_instr, slot0_tag, slot0_valid, slot0_flag,
                 slot1_instr, slot1_tag, slot1_valid, slot1_flag}), 80'd0);
        cycle(1'b0, "reissue");
        cmp("reissue_b0", 80'({uop_addr, slot0_valid, slot1_valid, halted, slot0_instr}),
            80'({7'd1, 1'b1, 1'b1, 1'b0, 32'h01205021}));

        // bubble, then valid bundle, then slot-0 terminator
        mem[0] = {mk_slot(32'h11111111, 2'd1, 1'b0, 1'b1), mk_slot(32'h22222222, 2'd3, 1'b0, 1'b0)};
        mem[1] = {mk_slot(32'h33333333, 2'd0, 1'b1, 1'b0), mk_slot(32'h44444444, 2'd1, 1'b0, 1'b1)};
        mem[2] = {mk_slot(32'h0, 2'd0, 1'b1, 1'b0), mk_slot(32'h55555555, 2'd2, 1'b1, 1'b1)};
        cycle(1'b1, "bubble_reset");
        cycle(1'b0, "bubble");
        cmp("bubble_adv", 80'({uop_addr, slot0_valid, slot1_valid, halted}), 80'({7'd1, 3'b000}));
        cycle(1'b0, "after_bubble");
        cmp("after_bubble", 80'({uop_addr, slot0_valid, slot1_valid, halted}), 80'({7'd2, 3'b100}));
        cycle(1'b0, "term0");
        cmp("term0_kill", 80'({uop_addr, slot0_valid, slot1_valid, halted, slot1_instr}),
            80'({7'd2, 3'b001, 32'h55555555}));
`ifdef MICROCODE_BUNDLE_COUNT_EN
        cmp("bubble_count", 80'(bundle_count), 80'd1);
`endif

        // no terminator anywhere: address must wrap without a gap
        for (int i = 0; i < SIZE; i++) mem[i] = {rand_slot(0), rand_slot(0)};
        cycle(1'b1, "wrap_reset");
        for (int k = 1; k <= 300; k++) begin
            cycle(1'b0, "wrap");
            if (k == 128 || k == 129) cmp("wrap_addr", 80'(uop_addr), 80'(k % SIZE));
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < SIZE; i++) mem[i] = {rand_slot(1), rand_slot(1)};
            cycle(1'b1, "rand_reset");
            repeat (200) cycle(($urandom_range(0, 39) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
